dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, memory address width in bits.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, legal range 1..15; maximum consecutive cycles a pending host request may be refused.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- arst  in  1  asynchronous, active-high reset.
- enable  in  1  run enable; low freezes all state.
- cpu_req  in  1  CPU MEM-stage access request.
- cpu_wen  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  CPU request issued this cycle.
- cpu_stall  out  1  CPU pipeline hold.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- host_req  in  1  host/DMA access request.
- host_wen  in  1  1 = write, 0 = read.
- host_lock  in  1  host requests back-to-back ownership.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  host request issued this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- mem_addr  out  ADDR_W  data SRAM address.
- mem_wen  out  1  data SRAM write enable.
- mem_ren  out  1  data SRAM read enable.
- mem_wdata  out  DATA_W  data SRAM write data.
- mem_rdata  in  DATA_W  data SRAM read data; valid the cycle after mem_ren.

Function
REQ-005 SHALL keep a registered owner state: IDLE, CPU, HOST.
REQ-006 SHALL grant at most one requester per cycle; priority order, first match wins:
- (a) state HOST, host_lock=1, host_req=1 -> host.
- (b) wait_cnt == STARVE_LIMIT and host_req=1 -> host.
- (c) cpu_req=1 -> cpu.
- (d) host_req=1 -> host.
- (e) otherwise no grant.
REQ-007 SHALL, when enable=0, grant nothing, hold state, wait_cnt and rvalid flags unchanged, and drive mem_wen=mem_ren=0.
REQ-008 SHALL drive the granted request's address, wdata, wen=req_wen and ren=!req_wen to memory in the same cycle, combinationally; the matching ack pulses that cycle.
REQ-009 SHALL, with no grant, drive mem_wen=mem_ren=0 and mem_addr=mem_wdata=0.
REQ-010 SHALL set next state to the owner granted this cycle, or IDLE if none.
REQ-011 SHALL hold cpu_stall = cpu_req & !cpu_ack.
REQ-012 SHALL keep a 4-bit wait_cnt:
- Increments, saturating at STARVE_LIMIT, each enabled cycle with host_req=1 and host_ack=0.
- Clears when host_ack=1 or host_req=0.
REQ-013 SHALL register xx_rvalid <= xx_ack & !xx_wen, giving read latency of exactly one cycle after ack.
REQ-014 SHALL drive xx_rdata = mem_rdata while xx_rvalid=1, else 0.
REQ-015 SHALL treat requests as level-held: a requester keeps req and its fields stable until ack; ack consumes exactly one access.
REQ-016 SHALL, when host_lock drops while state is HOST, re-arbitrate by (b)-(e) in that same cycle.
REQ-017 SHALL produce no ack, no mem enable and no rvalid when neither requester is active.

Reset
REQ-018 SHALL, while arst=1, asynchronously force state=IDLE, wait_cnt=0, cpu_rvalid=host_rvalid=0.
REQ-019 SHALL, while arst=1, suppress all acks and mem enables, so cpu_stall equals cpu_req and an access in flight is dropped.
REQ-020 SHALL resume arbitration on the first rising clk edge after arst deasserts.

Verification
REQ-021 CPU read only: cpu_req=1, cpu_wen=0, cpu_addr=0x40 -> cpu_ack=1, mem_ren=1, mem_addr=0x40 same cycle; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata.
REQ-022 Contention, STARVE_LIMIT=8: both req held continuously -> CPU acked cycles 0-7; wait_cnt reaches 8; host acked cycle 8 with cpu_stall=1; CPU acked cycle 9.
REQ-023 Lock: host holds req+lock for 4 writes while cpu_req=1 -> 4 consecutive host_acks, cpu_stall=1 throughout; lock drop -> cpu_ack in the same cycle.
REQ-024 enable=0 for 3 cycles with both req=1 -> no acks, mem_wen=mem_ren=0, wait_cnt unchanged; arbitration resumes when enable returns to 1.
REQ-025 Reset mid-read: arst pulsed in the cycle after a host read ack -> host_rvalid=0 immediately, state IDLE, wait_cnt=0.
REQ-026 Write: host_req=1, host_wen=1, host_addr=0x8, host_wdata=0xDEAD -> mem_wen=1 with those values, host_ack=1, host_rvalid stays 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one SRAM port between the CPU MEM stage
// and a host/DMA master, with host lock and starvation protection.
module dmem_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wen,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    HOST
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       active;
  logic       lock_hit;
  logic       starve;
  logic       grant_host;
  logic       grant_cpu;

  // Reset and enable both gate every grant, so no access leaks out.
  assign active   = enable & ~arst;
  assign lock_hit = (state == HOST) & host_lock & host_req;
  assign starve   = (wait_cnt == LIMIT) & host_req;

  assign grant_host = active & (lock_hit | starve | (~cpu_req & host_req));
  assign grant_cpu  = active & ~lock_hit & ~starve & cpu_req;

  assign cpu_ack   = grant_cpu;
  assign host_ack  = grant_host;
  assign cpu_stall = cpu_req & ~grant_cpu;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    unique case (1'b1)
      grant_cpu: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wen   = cpu_wen;
        mem_ren   = ~cpu_wen;
      end
      grant_host: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_wen   = host_wen;
        mem_ren   = ~host_wen;
      end
      default: ;
    endcase
  end

  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata = host_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else if (enable) begin
      if (grant_host)     state <= HOST;
      else if (grant_cpu) state <= CPU;
      else                state <= IDLE;
      if (host_req & ~grant_host) begin
        if (wait_cnt < LIMIT) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
      cpu_rvalid  <= grant_cpu & ~cpu_wen;
      host_rvalid <= grant_host & ~host_wen;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, corner sequences and a
// randomized run against a request-level reference model.
module tb_dmem_port_arbiter;

  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        arst;
  logic        enable;
  logic        cpu_req, cpu_wen;
  logic [63:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_stall, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        host_req, host_wen, host_lock;
  logic [63:0] host_addr, host_wdata;
  logic        host_ack, host_rvalid;
  logic [63:0] host_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(
    .DATA_W(64), .ADDR_W(64), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_wen(host_wen),
    .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: owner 0=none 1=cpu 2=host
  int m_owner;
  int m_wait;
  bit m_crv, m_hrv;

  function automatic int mgrant();
    if (arst || !enable) return 0;
    if (m_owner == 2 && host_lock && host_req) return 2;
    if (m_wait == SL && host_req) return 2;
    if (cpu_req) return 1;
    if (host_req) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_owner <= 0;
      m_wait  <= 0;
      m_crv   <= 1'b0;
      m_hrv   <= 1'b0;
    end else if (enable) begin
      m_owner <= mgrant();
      if (host_req && mgrant() != 2)
        m_wait <= (m_wait + 1 > SL) ? SL : m_wait + 1;
      else
        m_wait <= 0;
      m_crv <= (mgrant() == 1) && !cpu_wen;
      m_hrv <= (mgrant() == 2) && !host_wen;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_wen = 0; host_lock = 0;
    host_addr = 0; host_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    arst = 1'b1;
    #2;
    arst = 1'b0;
  endtask

  task automatic both(bit en);
    enable = en;
    cpu_req = 1; cpu_wen = 1; cpu_addr = 64'h100; cpu_wdata = 64'h1;
    host_req = 1; host_wen = 1; host_lock = 0;
    host_addr = 64'h200; host_wdata = 64'h2;
  endtask

  typedef struct {
    bit en, cr, cw;
    logic [63:0] ca, cd;
    bit hr, hw, hl;
    logic [63:0] ha, hd;
    bit e_cack, e_hack, e_st, e_mw, e_mr;
    logic [63:0] e_madr, e_mwd;
    bit e_crv, e_hrv;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(bit en, bit cr, bit cw, logic [63:0] ca,
                              logic [63:0] cd, bit hr, bit hw, bit hl,
                              logic [63:0] ha, logic [63:0] hd,
                              bit cak, bit hak, bit st, bit mw, bit mr,
                              logic [63:0] madr, logic [63:0] mwd,
                              bit crv, bit hrv);
    vec_t v;
    v.en = en; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.hl = hl; v.ha = ha; v.hd = hd;
    v.e_cack = cak; v.e_hack = hak; v.e_st = st;
    v.e_mw = mw; v.e_mr = mr; v.e_madr = madr; v.e_mwd = mwd;
    v.e_crv = crv; v.e_hrv = hrv;
    return v;
  endfunction

  int prev_g;

  initial begin
    arst = 1'b1;
    idle_inputs();
    cpu_req = 1; host_req = 1;
    mem_rdata = 64'hA5A5;
    #3;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_mem_en", {mem_wen, mem_ren}, 0);
    chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
    chk("rst_rdata", cpu_rdata | host_rdata, 0);

    vt[0]  = mk(1,1,0,'h40,0, 0,0,0,0,0,     1,0,0,0,1,'h40,0,     0,0);
    vt[1]  = mk(1,0,0,0,0,    1,1,0,'h8,'hDEAD, 0,1,0,1,0,'h8,'hDEAD, 1,0);
    vt[2]  = mk(1,0,0,0,0,    0,0,0,0,0,     0,0,0,0,0,0,0,        0,0);
    vt[3]  = mk(1,1,1,'h10,'h11, 1,0,0,'h20,0, 1,0,0,1,0,'h10,'h11, 0,0);
    vt[4]  = mk(0,1,1,'h10,'h11, 1,0,0,'h20,0, 0,0,1,0,0,0,0,       0,0);
    vt[5]  = mk(1,0,0,0,0,    1,0,0,'h20,0,  0,1,0,0,1,'h20,0,     0,0);
    vt[6]  = mk(1,0,0,0,0,    0,0,0,0,0,     0,0,0,0,0,0,0,        0,1);
    vt[7]  = mk(1,1,0,'h44,0, 1,1,1,'h50,'h55, 1,0,0,0,1,'h44,0,   0,0);
    vt[8]  = mk(1,0,0,0,0,    1,1,1,'h58,'h66, 0,1,0,1,0,'h58,'h66, 1,0);
    vt[9]  = mk(1,1,0,'h48,0, 1,1,1,'h60,'h77, 0,1,1,1,0,'h60,'h77, 0,0);
    vt[10] = mk(1,1,0,'h48,0, 1,1,0,'h60,'h77, 1,0,0,0,1,'h48,0,   0,0);
    vt[11] = mk(1,0,0,0,0,    0,0,0,0,0,     0,0,0,0,0,0,0,        1,0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      enable = vt[i].en;
      cpu_req = vt[i].cr; cpu_wen = vt[i].cw;
      cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      host_req = vt[i].hr; host_wen = vt[i].hw; host_lock = vt[i].hl;
      host_addr = vt[i].ha; host_wdata = vt[i].hd;
      mem_rdata = 64'h1000 + 64'(i);
      #1;
      chk($sformatf("v%0d_cpu_ack", i), cpu_ack, vt[i].e_cack);
      chk($sformatf("v%0d_host_ack", i), host_ack, vt[i].e_hack);
      chk($sformatf("v%0d_stall", i), cpu_stall, vt[i].e_st);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, vt[i].e_mw);
      chk($sformatf("v%0d_mem_ren", i), mem_ren, vt[i].e_mr);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_madr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_mwd);
      chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vt[i].e_crv);
      chk($sformatf("v%0d_host_rvalid", i), host_rvalid, vt[i].e_hrv);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata,
          vt[i].e_crv ? mem_rdata : 64'h0);
    end

    // Starvation: CPU wins 8 times, host on cycle 8, CPU again on 9
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      both(1);
      #1;
      chk($sformatf("starve%0d_host_ack", i), host_ack, i == 8);
      chk($sformatf("starve%0d_cpu_ack", i), cpu_ack, i != 8);
      chk($sformatf("starve%0d_stall", i), cpu_stall, i == 8);
    end

    // Lock: host owns the port for back-to-back writes, then releases
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      both(1);
      cpu_req = (i != 0);
      host_lock = (i < 5);
      host_addr = 64'h300 + 64'(i * 8);
      #1;
      chk($sformatf("lock%0d_host_ack", i), host_ack, i < 5);
      chk($sformatf("lock%0d_cpu_ack", i), cpu_ack, i == 5);
      chk($sformatf("lock%0d_stall", i), cpu_stall, i != 0 && i < 5);
      if (i < 5) chk($sformatf("lock%0d_addr", i), mem_addr, host_addr);
    end

    // Enable low must freeze the wait counter at 7
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      both(!(i >= 7 && i < 10));
      #1;
      if (i >= 7 && i < 10) begin
        chk($sformatf("en%0d_acks", i), {cpu_ack, host_ack}, 0);
        chk($sformatf("en%0d_mem", i), {mem_wen, mem_ren}, 0);
        chk($sformatf("en%0d_stall", i), cpu_stall, 1);
      end else begin
        chk($sformatf("en%0d_host_ack", i), host_ack, i == 11);
        chk($sformatf("en%0d_cpu_ack", i), cpu_ack, i != 11);
      end
    end

    // Reset in the cycle after a host read ack
    do_reset();
    @(negedge clk);
    host_req = 1; host_wen = 0; host_addr = 64'h100;
    #1;
    chk("rr_host_ack", host_ack, 1);
    chk("rr_mem_ren", mem_ren, 1);
    @(negedge clk);
    host_req = 0;
    mem_rdata = 64'h1234;
    #1;
    chk("rr_host_rvalid", host_rvalid, 1);
    chk("rr_host_rdata", host_rdata, 64'h1234);
    cpu_req = 1; host_req = 1; host_lock = 1; host_wen = 1;
    arst = 1;
    #1;
    chk("rr_rst_rvalid", host_rvalid, 0);
    chk("rr_rst_rdata", host_rdata, 0);
    chk("rr_rst_acks", {cpu_ack, host_ack}, 0);
    chk("rr_rst_stall", cpu_stall, 1);
    chk("rr_rst_mem", {mem_wen, mem_ren}, 0);
    arst = 0;
    #1;
    chk("rr_idle_cpu_ack", cpu_ack, 1);
    chk("rr_idle_host_ack", host_ack, 0);

    // Randomized run against the reference model
    do_reset();
    prev_g = 0;
    for (int n = 0; n < 3000; n++) begin
      int g;
      @(negedge clk);
      if (!(cpu_req && prev_g != 1)) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_wen = $urandom_range(0, 1) == 1;
        cpu_addr = {$urandom(), $urandom()};
        cpu_wdata = {$urandom(), $urandom()};
      end
      if (!(host_req && prev_g != 2)) begin
        host_req = ($urandom_range(0, 3) != 0);
        host_wen = $urandom_range(0, 1) == 1;
        host_addr = {$urandom(), $urandom()};
        host_wdata = {$urandom(), $urandom()};
      end
      host_lock = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 9) != 0);
      mem_rdata = {$urandom(), $urandom()};
      #1;
      g = mgrant();
      prev_g = g;
      chk("rnd_cpu_ack", cpu_ack, g == 1);
      chk("rnd_host_ack", host_ack, g == 2);
      chk("rnd_stall", cpu_stall, cpu_req && g != 1);
      chk("rnd_mem_wen", mem_wen,
          (g == 1 && cpu_wen) || (g == 2 && host_wen));
      chk("rnd_mem_ren", mem_ren,
          (g == 1 && !cpu_wen) || (g == 2 && !host_wen));
      chk("rnd_mem_addr", mem_addr,
          g == 1 ? cpu_addr : g == 2 ? host_addr : 64'h0);
      chk("rnd_mem_wdata", mem_wdata,
          g == 1 ? cpu_wdata : g == 2 ? host_wdata : 64'h0);
      chk("rnd_cpu_rvalid", cpu_rvalid, m_crv);
      chk("rnd_host_rvalid", host_rvalid, m_hrv);
      chk("rnd_cpu_rdata", cpu_rdata, m_crv ? mem_rdata : 64'h0);
      chk("rnd_host_rdata", host_rdata, m_hrv ? mem_rdata : 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
